// File: rtl/sdio_rx.sv
// SD CMD-line response receiver: hunts for the start bit, shifts in a 48-bit (or 136-bit R2)
// frame, checks direction/CRC7/end bits. Define SDIO_RX_LONG_RESP_EN for the 136-bit R2 path.
module sdio_rx #(
  parameter logic [15:0] TIMEOUT_CLKS = 16'd64
) (
  input  logic         ctrl_clk,
  input  logic         rst,
  input  logic         sdio_clk,
  input  logic         sdio_cmd_i,
  input  logic         i_en,
  input  logic         i_long,
  input  logic         i_crc_chk,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout,
  output logic         o_crc_err,
  output logic         o_frame_err,
  output logic [5:0]   o_cmd_idx,
  output logic [31:0]  o_resp
`ifdef SDIO_RX_LONG_RESP_EN
  ,
  output logic [119:0] o_resp_long
`endif
);

`ifdef SDIO_RX_LONG_RESP_EN
  localparam int unsigned SW = 136;
`else
  localparam int unsigned SW = 48;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          sclk_q;
  logic          chk_q, chk_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [7:0]    bcnt_q, bcnt_d;
  logic [6:0]    crc_q, crc_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          to_q, to_d, ce_q, ce_d, fe_q, fe_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   resp_q, resp_d;
  logic          rise, fb, feed, last, long_mode;
  logic [6:0]    crc_nx;

`ifdef SDIO_RX_LONG_RESP_EN
  logic          long_q, long_d;
  logic [119:0]  rl_q, rl_d;
  assign long_mode   = long_q;
  assign o_resp_long = rl_q;
`else
  logic unused_long;
  assign unused_long = i_long;
  assign long_mode   = 1'b0;
`endif

  assign rise   = sdio_clk & ~sclk_q;
  assign fb     = sdio_cmd_i ^ crc_q[6];
  assign crc_nx = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
  // R2 CRC covers only the 120 content bits; short frames cover start through argument.
  assign feed   = long_mode ? (bcnt_q >= 8'd8 && bcnt_q <= 8'd127) : (bcnt_q <= 8'd39);
  assign last   = long_mode ? (bcnt_q == 8'd135) : (bcnt_q == 8'd47);

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    to_d    = to_q;
    ce_d    = ce_q;
    fe_d    = fe_q;
    idx_d   = idx_q;
    resp_d  = resp_q;
`ifdef SDIO_RX_LONG_RESP_EN
    long_d  = long_q;
    rl_d    = rl_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
`ifdef SDIO_RX_LONG_RESP_EN
          long_d = i_long;
`endif
          chk_d   = i_crc_chk;
          tcnt_d  = '0;
          bcnt_d  = '0;
          crc_d   = '0;
          sh_d    = '0;
          to_d    = 1'b0;
          ce_d    = 1'b0;
          fe_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!sdio_cmd_i) begin
            // Start bit is 0 into a cleared CRC, so feeding it would leave CRC at 0 anyway.
            bcnt_d  = 8'd1;
            sh_d    = {sh_q[SW-2:0], 1'b0};
            state_d = S_RECV;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
            if (tcnt_d == TIMEOUT_CLKS) begin
              to_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_RECV: begin
        if (rise) begin
          sh_d   = {sh_q[SW-2:0], sdio_cmd_i};
          bcnt_d = bcnt_q + 8'd1;
          if (bcnt_q == 8'd1 && sdio_cmd_i) fe_d = 1'b1;
          if (feed) crc_d = crc_nx;
          if (last) begin
            if (!sdio_cmd_i) fe_d = 1'b1;
            if (chk_q && (sh_d[7:1] != crc_q)) ce_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
`ifdef SDIO_RX_LONG_RESP_EN
            rl_d = sh_d[127:8];
            if (long_mode) begin
              idx_d  = sh_d[133:128];
              resp_d = sh_d[127:96];
            end else begin
              idx_d  = sh_d[45:40];
              resp_d = sh_d[39:8];
            end
`else
            idx_d  = sh_d[45:40];
            resp_d = sh_d[39:8];
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ctrl_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sclk_q  <= 1'b0;
      chk_q   <= 1'b0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      crc_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      ce_q    <= 1'b0;
      fe_q    <= 1'b0;
      idx_q   <= '0;
      resp_q  <= '0;
`ifdef SDIO_RX_LONG_RESP_EN
      long_q  <= 1'b0;
      rl_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sclk_q  <= sdio_clk;
      chk_q   <= chk_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      ce_q    <= ce_d;
      fe_q    <= fe_d;
      idx_q   <= idx_d;
      resp_q  <= resp_d;
`ifdef SDIO_RX_LONG_RESP_EN
      long_q  <= long_d;
      rl_q    <= rl_d;
`endif
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = to_q;
  assign o_crc_err   = ce_q;
  assign o_frame_err = fe_q;
  assign o_cmd_idx   = idx_q;
  assign o_resp      = resp_q;

endmodule

// File: tb/tb_sdio_rx.sv
// Scoreboard bench for sdio_rx: expected completions are queued at stimulus time and popped on o_done.
module tb_sdio_rx;
  logic        ctrl_clk = 1'b0;
  logic        sdio_clk = 1'b0;
  logic        rst, sdio_cmd_i, i_en, i_long, i_crc_chk;
  logic        o_busy, o_done, o_timeout, o_crc_err, o_frame_err;
  logic [5:0]  o_cmd_idx;
  logic [31:0] o_resp;
`ifdef SDIO_RX_LONG_RESP_EN
  logic [119:0] o_resp_long;
`endif

  sdio_rx #(.TIMEOUT_CLKS(16'd64)) dut (
    .ctrl_clk    (ctrl_clk),
    .rst         (rst),
    .sdio_clk    (sdio_clk),
    .sdio_cmd_i  (sdio_cmd_i),
    .i_en        (i_en),
    .i_long      (i_long),
    .i_crc_chk   (i_crc_chk),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_crc_err   (o_crc_err),
    .o_frame_err (o_frame_err),
    .o_cmd_idx   (o_cmd_idx),
    .o_resp      (o_resp)
`ifdef SDIO_RX_LONG_RESP_EN
    ,
    .o_resp_long (o_resp_long)
`endif
  );

  always #5 ctrl_clk = ~ctrl_clk;
  initial begin
    #3;
    forever #40 sdio_clk = ~sdio_clk;
  end

  typedef struct {
    logic         to, ce, fe, chk_rl;
    logic [5:0]   idx;
    logic [31:0]  resp;
    logic [119:0] rl;
    int           edges;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          edge_cnt = 0;
  logic [5:0]  last_idx = '0;
  logic [31:0] last_resp = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
    logic [6:0] c;
    logic       f;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      f = v[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (f) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always @(posedge sdio_clk) edge_cnt++;

  always @(negedge ctrl_clk) begin : mon
    exp_t e;
    if (o_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("busy_at_done", o_busy, 0);
        check("timeout", o_timeout, e.to);
        check("crc_err", o_crc_err, e.ce);
        check("frame_err", o_frame_err, e.fe);
        check("cmd_idx", o_cmd_idx, e.idx);
        check("resp", o_resp, e.resp);
        check("edges_to_done", edge_cnt, e.edges);
`ifdef SDIO_RX_LONG_RESP_EN
        if (e.chk_rl) check("resp_long", o_resp_long, e.rl);
`endif
      end
    end
  end

  task automatic arm(input logic lng, input logic chk);
    @(negedge sdio_clk);
    @(negedge ctrl_clk);
    i_en = 1'b1; i_long = lng; i_crc_chk = chk; edge_cnt = 0;
    @(negedge ctrl_clk);
    i_en = 1'b0;
    check("busy_after_arm", o_busy, 1);
  endtask

  // Drives `idle` high edges (the first falls before any negedge) then len frame bits MSB first.
  task automatic send(input logic [135:0] fr, input int len, input int idle);
    repeat (idle - 1) begin
      @(negedge sdio_clk);
      sdio_cmd_i = 1'b1;
    end
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge sdio_clk);
      sdio_cmd_i = fr[i];
    end
    @(negedge sdio_clk);
    sdio_cmd_i = 1'b1;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt <= d0 && k < 3000) begin
      @(negedge ctrl_clk);
      k++;
    end
    if (done_cnt <= d0) check("done_wait_expired", 0, 1);
  endtask

  task automatic do_frame(input logic [135:0] fr, input int len, input logic lng,
                          input logic chk, input logic ce, input logic fe);
    exp_t e;
    int   d0;
    e.to = 1'b0; e.ce = ce; e.fe = fe; e.chk_rl = (len == 136);
    if (len == 136) begin
      e.idx = fr[133:128]; e.resp = fr[127:96]; e.rl = fr[127:8];
    end else begin
      e.idx = fr[45:40]; e.resp = fr[39:8]; e.rl = '0;
    end
    e.edges = 5 + len;
    last_idx = e.idx; last_resp = e.resp;
    sb.push_back(e);
    d0 = done_cnt;
    arm(lng, chk);
    send(fr, len, 5);
    wait_done(d0);
  endtask

  initial begin : main
    exp_t         e;
    int           d0;
    logic [135:0] fr;
    logic [119:0] content;
    rst = 1'b1; sdio_cmd_i = 1'b1; i_en = 1'b0; i_long = 1'b0; i_crc_chk = 1'b0;
    repeat (3) @(negedge ctrl_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_crc_err", o_crc_err, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_idx", o_cmd_idx, 0);
    check("rst_resp", o_resp, 0);
    rst = 1'b0;
    repeat (2) @(negedge ctrl_clk);

    do_frame({88'd0, 48'h0800_0001_AA13}, 48, 1'b0, 1'b1, 1'b0, 1'b0);  // R7 good
    do_frame({88'd0, 48'h0800_0001_AB13}, 48, 1'b0, 1'b1, 1'b1, 1'b0);  // argument bit flipped
    do_frame({88'd0, 48'h3F80_FF80_00FF}, 48, 1'b0, 1'b0, 1'b0, 1'b0);  // R3, CRC unchecked
    do_frame({88'd0, 48'h3F80_FF80_00FF}, 48, 1'b0, 1'b1, 1'b1, 1'b0);  // R3, CRC checked

    // Line stays high: timeout at the 64th edge, data outputs keep previous values.
    e.to = 1'b1; e.ce = 1'b0; e.fe = 1'b0; e.chk_rl = 1'b0;
    e.idx = last_idx; e.resp = last_resp; e.rl = '0; e.edges = 64;
    sb.push_back(e);
    d0 = done_cnt;
    arm(1'b0, 1'b1);
    wait_done(d0);

    do_frame({88'd0, 48'h0800_0001_AA12}, 48, 1'b0, 1'b1, 1'b0, 1'b1);  // end bit 0
    do_frame({88'd0, 48'h4800_0001_AA13}, 48, 1'b0, 1'b1, 1'b1, 1'b1);  // direction bit 1

    // Reset after bit 20 of a frame.
    fr = {88'd0, 48'h0800_0001_AA13};
    arm(1'b0, 1'b1);
    repeat (4) begin
      @(negedge sdio_clk);
      sdio_cmd_i = 1'b1;
    end
    for (int i = 47; i >= 27; i--) begin
      @(negedge sdio_clk);
      sdio_cmd_i = fr[i];
    end
    @(posedge sdio_clk);
    @(negedge ctrl_clk);
    rst = 1'b1;
    @(negedge ctrl_clk);
    check("midrst_busy", o_busy, 0);
    check("midrst_frame_err", o_frame_err, 0);
    check("midrst_crc_err", o_crc_err, 0);
    check("midrst_idx", o_cmd_idx, 0);
    check("midrst_resp", o_resp, 0);
    rst = 1'b0;
    sdio_cmd_i = 1'b1;
    repeat (2) @(negedge ctrl_clk);
    do_frame({88'd0, 48'h0800_0001_AA13}, 48, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SDIO_RX_LONG_RESP_EN
    content = 120'h0123_4567_89AB_CDEF_0123_4567_89AB_CD;
    fr = {2'b00, 6'h3F, content, crc7({16'd0, content}, 120), 1'b1};
    do_frame(fr, 136, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    content = '0;
`endif

    repeat (20) @(negedge ctrl_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sdio_rx.md
# sdio_rx

Host-side SD command-line response receiver. It sits directly downstream of the command transmitter `sdio_tx` on the bidirectional CMD line. Once armed after a command is sent, it hunts for the card's start bit and shifts in a 48-bit response, or a 136-bit response when configured. It checks direction bit, CRC7 (x^7+x^3+1) and end bit, then presents the index, argument and status to the SD controller FSM. The timeout counter covers NCR.

## Interface
- TIMEOUT_CLKS, 64, sdio_clk rising edges to wait for a start bit before timeout; 16-bit unsigned, must be ≥1.
- ctrl_clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sdio_clk  in  1  SD bus clock, sampled as a level; a rising edge is `sdio_clk & ~sdio_clk_d`, where `sdio_clk_d` is sdio_clk registered on ctrl_clk.
- sdio_cmd_i  in  1  CMD line input; card drives on falling edges, bus idles high.
- i_en  in  1  one-cycle arm pulse, issued when `sdio_tx` o_busy falls.
- i_long  in  1  sampled at arm: 1 = 136-bit R2 frame, 0 = 48-bit frame.
- i_crc_chk  in  1  sampled at arm: 0 suppresses CRC error (R3).
- o_busy  out  1  high from arm until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  no start bit seen within TIMEOUT_CLKS edges.
- o_crc_err  out  1  received CRC7 ≠ computed CRC7 (only when checking is enabled).
- o_frame_err  out  1  direction bit = 1 or end bit = 0.
- o_cmd_idx  out  6  response bits 2–7.
- o_resp  out  32  response bits 8–39, MSB first.
- o_resp_long  out  120  R2 content bits 8–127; present only when SDIO_RX_LONG_RESP_EN is defined.

## Operation
- All outputs reset to 0. Reset mid-frame returns the block to IDLE, clears all outputs and the CRC register, and discards the partial frame.
- **IDLE**
  - On i_en: latch i_long and i_crc_chk, clear the timeout counter, CRC register and all status flags.
  - Set o_busy and go to WAIT.
  - Arm occurs only in IDLE; i_en is ignored in every other state.
- **WAIT**
  - On each sdio_clk rising edge, sample sdio_cmd_i.
  - Sample 0: this is the start bit (bit 0); set bit count to 1 and go to RECV.
  - Sample 1: increment the timeout counter. At the edge where it reaches TIMEOUT_CLKS, set o_timeout and go to DONE.
- **RECV**
  - Shift one bit per rising edge and increment the bit count.
  - Bit 1 (direction) must be 0; otherwise set the o_frame_err flag but keep receiving.
  - CRC7 feeds, using the same shift-register form as the transmitter:
    - 48-bit frame: feed bits 0–39 (start, direction, index, argument).
    - 136-bit frame: feed bits 8–127 only.
  - Compare the received CRC bits against the computed CRC:
    - 48-bit frame: bits 40–46.
    - 136-bit frame: bits 128–134.
  - Last bit is the end bit (bit 47 or bit 135) and must be 1. After sampling it, go to DONE.
- **DONE**
  - Update o_cmd_idx, o_resp and o_resp_long together from the shift register.
  - Pulse o_done for one cycle and clear o_busy in the same cycle. Go to IDLE.
  - Data and error outputs hold until the next arm.
  - On timeout, data outputs keep their previous values.
- For R2, o_cmd_idx reports the reserved bits (expected 6'h3F).

## Timing
- Sampling begins with the first sdio_clk rising edge after the arm cycle. If i_en coincides with an edge, that edge is not sampled.
- Latency: o_done asserts exactly 1 ctrl_clk after the ctrl_clk in which the end-bit edge was detected, or after the TIMEOUT_CLKS-th idle edge.
- Requires ctrl_clk ≥ 4× sdio_clk frequency. Each sdio_clk level must persist for ≥2 ctrl_clk cycles.
- One sample at most per sdio_clk rising edge, with no double-counting.

## Configuration
- `SDIO_RX_LONG_RESP_EN` defined:
  - i_long is honoured.
  - The 136-bit shift path and the o_resp_long port exist.
- `SDIO_RX_LONG_RESP_EN` undefined:
  - i_long is ignored and every frame is 48 bits.
  - o_resp_long port and 136-bit logic are removed.

## Test plan
- Arm with i_long=0, i_crc_chk=1; drive R7 48'h08_000001AA_13 after 5 idle edges → o_done, o_cmd_idx=8, o_resp=32'h000001AA, all error flags 0.
- Same frame with argument bit 0 flipped (…01AB…) → o_resp=32'h000001AB, o_crc_err=1, o_frame_err=0.
- R3 48'h3F_80FF8000_FF with i_crc_chk=0 → o_cmd_idx=6'h3F, o_resp=32'h80FF8000, no errors. Same frame with i_crc_chk=1 → o_crc_err=1.
- Hold CMD line high after arm, TIMEOUT_CLKS=64 → o_timeout=1 and o_done at the 64th edge; o_resp unchanged from previous value.
- End bit driven 0 → o_frame_err=1. Assert rst at bit 20 → all outputs 0 next cycle; a subsequent arm with a valid R7 completes correctly.
- With macro defined: i_long=1, R2 frame with content 120'h0123…, correct CRC → o_resp_long matches content, o_cmd_idx=6'h3F, o_crc_err=0.
